// File: rtl/aurora_pkg.sv
// Shared definitions for the 64B/66B Aurora receive path.
// Contents:
//   ENCODED_DATA_SIZE, DATA_SIZE, SYNC_HEADER_SIZE : word geometry
//   SH_DATA, SH_CTRL                               : the two legal sync headers
//   rx_lock_state_t                                : block-lock state machine states
//   sh_valid()                                     : true for a legal sync header
package aurora_pkg;

    localparam int unsigned ENCODED_DATA_SIZE = 66;
    localparam int unsigned DATA_SIZE         = 64;
    localparam int unsigned SYNC_HEADER_SIZE  = 2;

    localparam logic [SYNC_HEADER_SIZE-1:0] SH_DATA = 2'b01;
    localparam logic [SYNC_HEADER_SIZE-1:0] SH_CTRL = 2'b10;

    typedef enum logic [1:0] {
        HUNT,
        SLIP,
        LOCKED
    } rx_lock_state_t;

    function automatic logic sh_valid(input logic [SYNC_HEADER_SIZE-1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/aurora_descrambler.sv
// Self-synchronizing x^58 + x^39 + 1 descrambler for one 64-bit payload word.
// Only instantiated when AURORA_RX_DESCRAMBLER_EN is defined.
// Ports:
//   clk  in  1  : clock
//   rst  in  1  : synchronous active-high reset, clears the scrambler history
//   en   in  1  : advance the history by the current word
//   din  in  64 : scrambled payload, bit 0 is the earliest bit
//   dout out 64 : descrambled payload (combinational from din and history)
module aurora_descrambler
    import aurora_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DATA_SIZE-1:0] din,
    output logic [DATA_SIZE-1:0] dout
);

    logic [57:0] state_q, state_d;

    always_comb begin
        logic [57:0] s;
        s    = state_q;
        dout = '0;
        // History holds received (scrambled) bits, newest in bit 0.
        for (int i = 0; i < int'(DATA_SIZE); i++) begin
            dout[i] = din[i] ^ s[38] ^ s[57];
            s       = {s[56:0], din[i]};
        end
        state_d = s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else if (en) begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/aurora_rx_lane.sv
// Receive lane for the 64B/66B Aurora link: bit-slip word alignment, sync-header
// block lock and optional payload descrambling (macro AURORA_RX_DESCRAMBLER_EN).
// Ports:
//   clk           in  1  : clock
//   rst           in  1  : synchronous active-high reset
//   data_in       in  66 : encoded lane word, bit 0 earliest
//   data_in_valid in  1  : data_in valid this cycle
//   data_out      out 64 : payload (descrambled when the macro is defined)
//   header_out    out 2  : sync header of the output word
//   data_valid    out 1  : output word valid
//   sh_err        out 1  : output word carries an illegal header
//   block_lock    out 1  : lane is block-locked
//   align_offset  out 7  : current slip offset, 0..65
module aurora_rx_lane
    import aurora_pkg::*;
#(
    parameter int unsigned SYNC_OK_CNT = 64,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned BAD_SH_MAX  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ENCODED_DATA_SIZE-1:0] data_in,
    input  logic                         data_in_valid,
    output logic [DATA_SIZE-1:0]         data_out,
    output logic [SYNC_HEADER_SIZE-1:0]  header_out,
    output logic                         data_valid,
    output logic                         sh_err,
    output logic                         block_lock,
    output logic [6:0]                   align_offset
);

    localparam int unsigned ShW  = $clog2(SYNC_OK_CNT + 1);
    localparam int unsigned WinW = $clog2(WINDOW + 1);
    localparam int unsigned BadW = $clog2(BAD_SH_MAX + 1);
    localparam logic [6:0]  LastOffset = 7'd65;

    rx_lock_state_t state_q, state_d;
    logic [ShW-1:0]  sh_cnt_q, sh_cnt_d;
    logic [WinW-1:0] win_cnt_q, win_cnt_d;
    logic [BadW-1:0] bad_cnt_q, bad_cnt_d;
    logic [6:0]      offset_d;
    logic            out_valid_d;

    logic [ENCODED_DATA_SIZE-1:0]   prev_q;
    logic                           primed_q;
    logic                           advance;
    logic [2*ENCODED_DATA_SIZE-1:0] stream;
    logic [7:0]                     sel;
    logic [ENCODED_DATA_SIZE-1:0]   window;
    logic [SYNC_HEADER_SIZE-1:0]    header;
    logic [DATA_SIZE-1:0]           payload;
    logic [DATA_SIZE-1:0]           payload_out;
    logic                           hdr_ok;

    // A word exists only once two input words have been seen.
    assign advance = data_in_valid & primed_q;
    assign stream  = {data_in, prev_q};
    assign sel     = {1'b0, align_offset};
    assign window  = stream[sel +: ENCODED_DATA_SIZE];
    assign header  = window[SYNC_HEADER_SIZE-1:0];
    assign payload = window[ENCODED_DATA_SIZE-1:SYNC_HEADER_SIZE];
    assign hdr_ok  = sh_valid(header);

`ifdef AURORA_RX_DESCRAMBLER_EN
    aurora_descrambler u_descrambler (
        .clk  (clk),
        .rst  (rst),
        .en   (advance),
        .din  (payload),
        .dout (payload_out)
    );
`else
    assign payload_out = payload;
`endif

    always_comb begin
        state_d     = state_q;
        sh_cnt_d    = sh_cnt_q;
        win_cnt_d   = win_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        offset_d    = align_offset;
        out_valid_d = 1'b0;
        if (advance) begin
            case (state_q)
                HUNT: begin
                    if (!hdr_ok) begin
                        state_d = SLIP;
                    end else if (sh_cnt_q == ShW'(SYNC_OK_CNT - 1)) begin
                        state_d  = LOCKED;
                        sh_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + ShW'(1);
                    end
                end
                SLIP: begin
                    // The word seen during SLIP is discarded unchecked.
                    offset_d  = (align_offset == LastOffset) ? 7'd0 : align_offset + 7'd1;
                    sh_cnt_d  = '0;
                    win_cnt_d = '0;
                    bad_cnt_d = '0;
                    state_d   = HUNT;
                end
                LOCKED: begin
                    out_valid_d = 1'b1;
                    // Loss of lock wins over a window end on the same word.
                    if (!hdr_ok && (bad_cnt_q == BadW'(BAD_SH_MAX - 1))) begin
                        state_d = SLIP;
                    end else if (win_cnt_q == WinW'(WINDOW - 1)) begin
                        win_cnt_d = '0;
                        bad_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WinW'(1);
                        if (!hdr_ok) begin
                            bad_cnt_d = bad_cnt_q + BadW'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            sh_cnt_q     <= '0;
            win_cnt_q    <= '0;
            bad_cnt_q    <= '0;
            align_offset <= '0;
            prev_q       <= '0;
            primed_q     <= 1'b0;
            block_lock   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_cnt_q     <= sh_cnt_d;
            win_cnt_q    <= win_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            align_offset <= offset_d;
            block_lock   <= (state_d == LOCKED);
            if (data_in_valid) begin
                prev_q   <= data_in;
                primed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            header_out <= '0;
            data_valid <= 1'b0;
            sh_err     <= 1'b0;
        end else begin
            data_valid <= out_valid_d;
            if (out_valid_d) begin
                data_out   <= payload_out;
                header_out <= header;
                sh_err     <= ~hdr_ok;
            end
        end
    end

endmodule

// File: tb/tb_aurora_rx_lane.sv
// Self-checking bench for aurora_rx_lane. Builds a 66-bit block bit stream (optionally
// scrambled and shifted by junk bits), slices it into lane words and compares the DUT
// against a bit-queue reference model. Honours AURORA_RX_DESCRAMBLER_EN.
module tb_aurora_rx_lane;
    import aurora_pkg::*;

    localparam int SYNC = 64;
    localparam int WIN  = 64;
    localparam int BAD  = 16;
    localparam int MHunt = 0, MSlip = 1, MLocked = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [65:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic [63:0] data_out;
    logic [1:0]  header_out;
    logic        data_valid, sh_err, block_lock;
    logic [6:0]  align_offset;

    aurora_rx_lane #(.SYNC_OK_CNT(SYNC), .WINDOW(WIN), .BAD_SH_MAX(BAD)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_out      (data_out),
        .header_out    (header_out),
        .data_valid    (data_valid),
        .sh_err        (sh_err),
        .block_lock    (block_lock),
        .align_offset  (align_offset)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transmit side
    bit          tx_bits[$];
    logic [63:0] src_pay[$];
    logic [1:0]  hdr_plan[$];
    logic [57:0] scr;
    bit          scr_en, inc_mode, fixed_hdr;

    // Reference model
    bit          rx_bits[$];
    int          m_state, m_sh, m_win, m_bad, m_off, m_nvalid;
    bit          m_primed;
    logic [57:0] m_desc;
    bit          exp_dv, exp_err, exp_lock;
    logic [1:0]  exp_hdr;
    logic [63:0] exp_data;

    task automatic refill_block();
        logic [1:0]  h;
        logic [63:0] p;
        bit          b;
        if (hdr_plan.size() > 0) h = hdr_plan.pop_front();
        else if (fixed_hdr) h = SH_DATA;
        else h = ($urandom_range(0, 1) == 0) ? SH_DATA : SH_CTRL;
        p = inc_mode ? 64'(src_pay.size()) : {$urandom(), $urandom()};
        src_pay.push_back(p);
        tx_bits.push_back(h[0]);
        tx_bits.push_back(h[1]);
        for (int i = 0; i < 64; i++) begin
            b = p[i];
            if (scr_en) begin
                b   = p[i] ^ scr[38] ^ scr[57];
                scr = {scr[56:0], b};
            end
            tx_bits.push_back(b);
        end
    endtask

    task automatic model_reset();
        rx_bits.delete();
        m_state = MHunt; m_sh = 0; m_win = 0; m_bad = 0; m_off = 0; m_nvalid = 0;
        m_primed = 0; m_desc = '0;
        exp_dv = 0; exp_err = 0; exp_lock = 0; exp_hdr = '0; exp_data = '0;
    endtask

    task automatic model_step(input logic [65:0] w, input bit v);
        logic [1:0]  h;
        logic [63:0] p, d;
        bit          ok, dummy;
        exp_dv = 0;
        if (!v) return;
        m_nvalid++;
        for (int i = 0; i < 66; i++) rx_bits.push_back(w[i]);
        if (!m_primed) begin
            m_primed = 1;
            return;
        end
        h = {rx_bits[m_off + 1], rx_bits[m_off]};
        for (int i = 0; i < 64; i++) p[i] = rx_bits[m_off + 2 + i];
        for (int i = 0; i < 66; i++) dummy = rx_bits.pop_front();
`ifdef AURORA_RX_DESCRAMBLER_EN
        for (int i = 0; i < 64; i++) begin
            d[i]   = p[i] ^ m_desc[38] ^ m_desc[57];
            m_desc = {m_desc[56:0], p[i]};
        end
`else
        d = p;
`endif
        ok = (h == SH_DATA) || (h == SH_CTRL);
        if (m_state == MHunt) begin
            if (!ok) m_state = MSlip;
            else if (m_sh == SYNC - 1) begin
                m_state = MLocked; m_sh = 0; m_win = 0; m_bad = 0;
            end else m_sh++;
        end else if (m_state == MSlip) begin
            m_off = (m_off + 1) % 66;
            m_sh = 0; m_win = 0; m_bad = 0;
            m_state = MHunt;
        end else begin
            exp_dv = 1; exp_hdr = h; exp_data = d; exp_err = !ok;
            if (!ok) m_bad++;
            m_win++;
            if (m_bad == BAD) m_state = MSlip;
            else if (m_win == WIN) begin m_win = 0; m_bad = 0; end
        end
        exp_lock = (m_state == MLocked);
    endtask

    task automatic cycle(input bit v);
        logic [95:0] r;
        logic [65:0] w;
        r = {$urandom(), $urandom(), $urandom()};
        w = r[65:0];
        if (v) begin
            while (tx_bits.size() < 200) refill_block();
            for (int i = 0; i < 66; i++) w[i] = tx_bits.pop_front();
        end
        data_in = w;
        data_in_valid = v;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(w, v);
        #1;
    endtask

    task automatic start_stream(input int junk, input bit s_en, input bit inc, input bit fixed);
        rst = 1'b1;
        cycle(1'b0);
        rst = 1'b0;
        tx_bits.delete(); src_pay.delete(); hdr_plan.delete();
        scr = 58'h3FF_FFFF_FFFF_FFFF;
        scr_en = s_en; inc_mode = inc; fixed_hdr = fixed;
        for (int i = 0; i < junk; i++) tx_bits.push_back(bit'($urandom_range(0, 1)));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cycle(bit'($urandom_range(0, 1)));
        checks++; if (data_out !== 64'd0) begin errors++; $display("FAIL reset_data got %h want 0", data_out); end
        checks++; if (header_out !== 2'd0) begin errors++; $display("FAIL reset_hdr got %b want 00", header_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", data_valid); end
        checks++; if (sh_err !== 1'b0) begin errors++; $display("FAIL reset_sherr got %b want 0", sh_err); end
        checks++; if (block_lock !== 1'b0) begin errors++; $display("FAIL reset_lock got %b want 0", block_lock); end
        checks++; if (align_offset !== 7'd0) begin errors++; $display("FAIL reset_off got %0d want 0", align_offset); end
        rst = 1'b0;
    endtask

    task automatic test_aligned_lock();
        start_stream(0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 66; i++) begin
            cycle(1'b1);
            checks++;
            if (block_lock !== exp_lock || align_offset !== 7'(m_off) || data_valid !== exp_dv ||
                (exp_dv && (data_out !== exp_data || header_out !== exp_hdr || sh_err !== exp_err))) begin
                errors++;
                $display("FAIL aligned_model i=%0d got lock=%b off=%0d dv=%b hdr=%b d=%h err=%b want lock=%b off=%0d dv=%b hdr=%b d=%h err=%b",
                         i, block_lock, align_offset, data_valid, header_out, data_out, sh_err,
                         exp_lock, m_off, exp_dv, exp_hdr, exp_data, exp_err);
            end
            if (i == 63) begin
                checks++;
                if (block_lock !== 1'b0) begin errors++; $display("FAIL aligned_early_lock got %b want 0", block_lock); end
            end
            if (i == 64) begin
                checks++;
                if (block_lock !== 1'b1) begin errors++; $display("FAIL aligned_lock got %b want 1", block_lock); end
            end
        end
        checks++;
        if (data_valid !== 1'b1 || header_out !== SH_DATA || data_out !== 64'd64) begin
            errors++;
            $display("FAIL aligned_first_word got dv=%b hdr=%b d=%h want dv=1 hdr=01 d=%h",
                     data_valid, header_out, data_out, 64'd64);
        end
    endtask

    task automatic test_offset5();
        int outs;
        outs = 0;
        start_stream(5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000 && outs < 20; i++) begin
            cycle($urandom_range(0, 3) != 0);
            checks++;
            if (block_lock !== exp_lock || align_offset !== 7'(m_off) || data_valid !== exp_dv ||
                (exp_dv && (data_out !== exp_data || header_out !== exp_hdr || sh_err !== exp_err))) begin
                errors++;
                $display("FAIL off5_model i=%0d got lock=%b off=%0d dv=%b hdr=%b d=%h err=%b want lock=%b off=%0d dv=%b hdr=%b d=%h err=%b",
                         i, block_lock, align_offset, data_valid, header_out, data_out, sh_err,
                         exp_lock, m_off, exp_dv, exp_hdr, exp_data, exp_err);
            end
            if (data_valid) begin
                outs++;
                checks++;
                if (data_out !== src_pay[m_nvalid - 2]) begin
                    errors++;
                    $display("FAIL off5_src got %h want %h", data_out, src_pay[m_nvalid - 2]);
                end
            end
        end
        checks++;
        if (outs < 20 || block_lock !== 1'b1 || align_offset !== 7'd5) begin
            errors++;
            $display("FAIL off5_lock got outs=%0d lock=%b off=%0d want outs=20 lock=1 off=5",
                     outs, block_lock, align_offset);
        end
    endtask

    // Continues the offset-5 stream: 15 bad headers in one window, then 16 in the next.
    task automatic test_bad_headers();
        int lag, pad, pulses;
        lag = src_pay.size() + 1 - m_nvalid;
        pad = (WIN - ((m_win + lag) % WIN)) % WIN;
        repeat (pad) hdr_plan.push_back(SH_DATA);
        repeat (15) hdr_plan.push_back(2'b00);
        repeat (49) hdr_plan.push_back(SH_CTRL);
        repeat (16) hdr_plan.push_back(2'b00);
        pulses = 0;
        for (int i = 0; i < lag + pad + 64 + 17; i++) begin
            cycle(1'b1);
            checks++;
            if (block_lock !== exp_lock || align_offset !== 7'(m_off) || data_valid !== exp_dv ||
                (exp_dv && (data_out !== exp_data || header_out !== exp_hdr || sh_err !== exp_err))) begin
                errors++;
                $display("FAIL bad_model i=%0d got lock=%b off=%0d dv=%b hdr=%b d=%h err=%b want lock=%b off=%0d dv=%b hdr=%b d=%h err=%b",
                         i, block_lock, align_offset, data_valid, header_out, data_out, sh_err,
                         exp_lock, m_off, exp_dv, exp_hdr, exp_data, exp_err);
            end
            if (data_valid && sh_err) pulses++;
            if (i == lag + pad + 63) begin
                checks++;
                if (pulses !== 15 || block_lock !== 1'b1) begin
                    errors++;
                    $display("FAIL bad15 got pulses=%0d lock=%b want 15 1", pulses, block_lock);
                end
                pulses = 0;
            end
            if (i == lag + pad + 78) begin
                checks++;
                if (block_lock !== 1'b1) begin errors++; $display("FAIL bad16_held got %b want 1", block_lock); end
            end
            if (i == lag + pad + 79) begin
                checks++;
                if (pulses !== 16 || block_lock !== 1'b0 || align_offset !== 7'd5) begin
                    errors++;
                    $display("FAIL bad16_drop got pulses=%0d lock=%b off=%0d want 16 0 5",
                             pulses, block_lock, align_offset);
                end
            end
        end
        checks++;
        if (align_offset !== 7'd6) begin errors++; $display("FAIL bad16_slip got off=%0d want 6", align_offset); end
    endtask

    task automatic test_offset65_wrap();
        int lag, pad;
        start_stream(65, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000 && !block_lock; i++) begin
            cycle(1'b1);
            checks++;
            if (block_lock !== exp_lock || align_offset !== 7'(m_off) || data_valid !== exp_dv) begin
                errors++;
                $display("FAIL off65_model i=%0d got lock=%b off=%0d dv=%b want lock=%b off=%0d dv=%b",
                         i, block_lock, align_offset, data_valid, exp_lock, m_off, exp_dv);
            end
        end
        checks++;
        if (block_lock !== 1'b1 || align_offset !== 7'd65) begin
            errors++;
            $display("FAIL off65_lock got lock=%b off=%0d want 1 65", block_lock, align_offset);
        end
        lag = src_pay.size() + 1 - m_nvalid;
        pad = (WIN - ((m_win + lag) % WIN)) % WIN;
        repeat (pad) hdr_plan.push_back(SH_CTRL);
        repeat (16) hdr_plan.push_back(2'b00);
        for (int i = 0; i < lag + pad + 16; i++) begin
            cycle(1'b1);
            checks++;
            if (block_lock !== exp_lock || align_offset !== 7'(m_off) || data_valid !== exp_dv ||
                (exp_dv && (data_out !== exp_data || header_out !== exp_hdr || sh_err !== exp_err))) begin
                errors++;
                $display("FAIL wrap_model i=%0d got lock=%b off=%0d dv=%b d=%h want lock=%b off=%0d dv=%b d=%h",
                         i, block_lock, align_offset, data_valid, data_out, exp_lock, m_off, exp_dv, exp_data);
            end
        end
        checks++;
        if (block_lock !== 1'b0) begin errors++; $display("FAIL wrap_drop got lock=%b want 0", block_lock); end
        cycle(1'b1);
        checks++;
        if (align_offset !== 7'd0) begin errors++; $display("FAIL wrap_off got %0d want 0", align_offset); end
    endtask

    task automatic test_scrambled_reset();
`ifdef AURORA_RX_DESCRAMBLER_EN
        start_stream(0, 1'b1, 1'b0, 1'b0);
`else
        start_stream(0, 1'b0, 1'b0, 1'b0);
`endif
        for (int i = 0; i < 66; i++) begin
            cycle(1'b1);
            checks++;
            if (block_lock !== exp_lock || data_valid !== exp_dv ||
                (exp_dv && (data_out !== exp_data || header_out !== exp_hdr))) begin
                errors++;
                $display("FAIL scr_model i=%0d got lock=%b dv=%b d=%h want lock=%b dv=%b d=%h",
                         i, block_lock, data_valid, data_out, exp_lock, exp_dv, exp_data);
            end
        end
        checks++;
        if (data_valid !== 1'b1 || data_out !== src_pay[64]) begin
            errors++;
            $display("FAIL scr_source got dv=%b d=%h want dv=1 d=%h", data_valid, data_out, src_pay[64]);
        end
        rst = 1'b1;
        cycle(1'b1);
        rst = 1'b0;
        checks++;
        if (block_lock !== 1'b0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got lock=%b dv=%b want 0 0", block_lock, data_valid);
        end
        for (int i = 0; i < 65; i++) begin
            cycle(1'b1);
            if (i == 63) begin
                checks++;
                if (block_lock !== 1'b0) begin errors++; $display("FAIL relock_early got %b want 0", block_lock); end
            end
        end
        checks++;
        if (block_lock !== 1'b1) begin errors++; $display("FAIL relock got %b want 1", block_lock); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_aligned_lock();
        test_offset5();
        test_bad_headers();
        test_offset65_wrap();
        test_scrambled_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aurora_rx_lane.md
# aurora_rx_lane

Receive-side lane block for the 64B/66B Aurora link, sitting directly downstream of `aurora_top` and consuming one lane of its `data_out` (one `ENCODED_DATA_SIZE`-bit word per lane). It aligns the incoming 66-bit word stream to block boundaries by bit-slipping, runs the sync-header block-lock state machine, and optionally descrambles the payload. It presents 64-bit payload words with their sync header to the RX framing logic. One instance is used per lane.

## Interface
Parameters:
- `SYNC_OK_CNT`, default 64: consecutive valid headers required to declare lock.
- `WINDOW`, default 64: size of the header-check window while locked, in words.
- `BAD_SH_MAX`, default 16: invalid headers within one window that cause loss of lock.

Ports:
- `clk`  in  1: clock, the same domain as `aurora_top`.
- `rst`  in  1: synchronous reset, active-high.
- `data_in`  in  `ENCODED_DATA_SIZE` (66): encoded lane word. Bit 0 is the earliest bit in the stream.
- `data_in_valid`  in  1: `data_in` is valid this cycle.
- `data_out`  out  64: payload, descrambled when the descrambler is compiled in.
- `header_out`  out  2: sync header of the output word.
- `data_valid`  out  1: output word is valid.
- `sh_err`  out  1: the output word has an invalid header (00 or 11). Qualified by `data_valid`.
- `block_lock`  out  1: the lane is block-locked.
- `align_offset`  out  7: current slip offset, 0..65.

## Operation
- Word alignment:
  - `prev` register holds the last valid `data_in`.
  - Aligned window = bits `[align_offset +: 66]` of `{data_in, prev}`.
  - Header = window[1:0]. Payload = window[65:2].
  - Valid headers are 01 (data) and 10 (control).
- Nothing advances while `data_in_valid`=0: counters, state, `prev` and descrambler state all hold, and `data_valid`=0.
- An aligned word is processed only when `data_in_valid`=1 and `prev` has been loaded at least once since reset (`primed` flag).
- State machine (`rx_lock_state_t`):
  - HUNT: valid header → `sh_cnt`++. When `sh_cnt`==`SYNC_OK_CNT`-1 and the header is valid → LOCKED. Invalid header → SLIP. No output.
  - SLIP: lasts one cycle with no word check. `align_offset` ← (`align_offset`==65) ? 0 : `align_offset`+1. Clears `sh_cnt`, `win_cnt` and `bad_cnt`. → HUNT.
  - LOCKED:
    - Every processed word is output, including bad-header words (with `sh_err`=1).
    - Each word increments `win_cnt`. Each invalid header increments `bad_cnt`.
    - When `bad_cnt` reaches `BAD_SH_MAX` → SLIP. That word is still output.
    - Otherwise, at `win_cnt`==`WINDOW`-1, both counters clear.
- `block_lock` = (state==LOCKED), registered.
- The word that completes lock is not output. The first output is the next processed word.

## Timing
- Reset values: `data_out`=0, `header_out`=0, `data_valid`=0, `sh_err`=0, `block_lock`=0, `align_offset`=0. State=HUNT, counters=0, `primed`=0, descrambler state=0.
- Latency: window word k is registered to the outputs on the edge that samples input word k+1. With continuous `data_in_valid`, first data is visible 2 cycles after the first valid input.
- `block_lock` rises in the cycle after the edge processing the `SYNC_OK_CNT`-th valid header. It falls in the cycle after the edge processing the `BAD_SH_MAX`-th bad header.
- The new `align_offset` applies to the first word processed after SLIP.
- Bad header and window end on the same word: loss of lock takes priority.
- `rst` mid-operation clears everything on the next edge regardless of `data_in_valid`.

## Configuration
- `AURORA_RX_DESCRAMBLER_EN` defined:
  - Payload passes through the self-synchronizing descrambler (x^58+x^39+1), processed bit 0 first: out = in ^ s[38] ^ s[57]; s = {s[56:0], in}.
  - The state updates on every processed word, whether locked or not.
- Not defined: `data_out` = raw aligned payload, and no descrambler logic is instantiated.

## Structure
- Defined in `aurora_pkg`:
  - constants `ENCODED_DATA_SIZE`=66, `DATA_SIZE`=64, `SYNC_HEADER_SIZE`=2, `SH_DATA`=2'b01, `SH_CTRL`=2'b10;
  - `typedef enum rx_lock_state_t {HUNT, SLIP, LOCKED}`.
- Sub-module `aurora_descrambler`:
  - ports: 64-bit in/out, an enable, and 58-bit state kept internally;
  - combinational output with registered state;
  - instantiated under the macro.

## Test plan
- Reset: assert `rst` for 3 cycles with random `data_in` → all outputs 0, `align_offset`=0.
- Aligned stream with header 01 and incrementing payload (macro off) → `block_lock`=1 after the 64th word. The 65th word appears with `data_valid`=1, `header_out`=01, payload exact.
- Same stream delayed by 5 bits, with random payloads → lock achieved with `align_offset`=5. Output payloads match the source.
- While locked, 15 bad headers (00) in one 64-word window → lock held and `sh_err` pulses 15 times. Repeat with 16 → `block_lock`=0 one cycle after the 16th, and `align_offset`++.
- Stream misaligned by 65 bits → lock reached at offset 65. Then force 16 bad headers → `align_offset` wraps to 0.
- Macro on, TB scrambler seeded 58'h3FF_FFFF_FFFF_FFFF → after lock plus 1 word, `data_out` equals the unscrambled source. Assert `rst` mid-lock → `block_lock` drops the next cycle and re-locks after 64 words.
